router_sync: RTL and testbench

//  Synchroniser/control glue between the router FSM and the three output FIFOs of a 1x3 packet router.
//  - Latches the 2-bit destination address when a header is detected.
//  - Steers the FSM write strobe to the addressed FIFO and reports that FIFO's full flag.
//  - Reports per-FIFO valid-data (not-empty).
//  - Runs a per-FIFO read-timeout watchdog that issues a soft reset to a FIFO whose data is not read in time.

---
 rtl/router_pkg.sv | 31 +++
 rtl/router_sync_timeout.sv | 61 ++++++
 rtl/router_sync.sv | 118 +++++++++++
 tb/tb_router_sync.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared definitions for the 1x3 packet router synchroniser:
//   - address width and the three valid FIFO address codes
//   - watchdog read-timeout length and counter width
//   - address-to-one-hot helper used for write strobe steering
// -----------------------------------------------------------------------------
package router_pkg;

  localparam int ADDR_W  = 2;
  localparam int CNT_W   = 5;
  localparam int TIMEOUT = 30;

  localparam logic [ADDR_W-1:0] ADDR_F0 = 2'b00;
  localparam logic [ADDR_W-1:0] ADDR_F1 = 2'b01;
  localparam logic [ADDR_W-1:0] ADDR_F2 = 2'b10;

  // Map a FIFO address to its one-hot write enable; the unused code 11
  // selects no FIFO so a bad header can never corrupt a queue.
  function automatic logic [2:0] addr_to_onehot(input logic [ADDR_W-1:0] addr);
    logic [2:0] onehot;
    case (addr)
      ADDR_F0: onehot = 3'b001;
      ADDR_F1: onehot = 3'b010;
      ADDR_F2: onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
    return onehot;
  endfunction

endpackage

// File: rtl/router_sync_timeout.sv
// -----------------------------------------------------------------------------
// router_sync_timeout
// Read-timeout watchdog for one output FIFO. Counts consecutive edges on
// which the FIFO holds data and is not read; on the TIMEOUT-th such edge it
// raises soft_reset for exactly one cycle and starts counting again.
// Ports:
//   clock      in  1  rising-edge clock
//   resetn     in  1  synchronous active-low reset
//   vld        in  1  FIFO holds data
//   read_enb   in  1  downstream read strobe
//   soft_reset out 1  one-cycle soft-reset pulse (registered)
// -----------------------------------------------------------------------------
module router_sync_timeout
  import router_pkg::*;
#(
  parameter int TIMEOUT_P = TIMEOUT
) (
  input  logic clock,
  input  logic resetn,
  input  logic vld,
  input  logic read_enb,
  output logic soft_reset
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_P - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             soft_reset_q;
  logic             soft_reset_d;

  // Next-state logic: any read or empty cycle restarts the count.
  always_comb begin
    cnt_d        = {CNT_W{1'b0}};
    soft_reset_d = 1'b0;
    if (!vld || read_enb) begin
      cnt_d        = {CNT_W{1'b0}};
      soft_reset_d = 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d        = {CNT_W{1'b0}};
      soft_reset_d = 1'b1;
    end else begin
      cnt_d        = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      soft_reset_d = 1'b0;
    end
  end

  // Counter and pulse registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt_q        <= {CNT_W{1'b0}};
      soft_reset_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      soft_reset_q <= soft_reset_d;
    end
  end

  assign soft_reset = soft_reset_q;

endmodule

// File: rtl/router_sync.sv
// -----------------------------------------------------------------------------
// router_sync
// Glue between the router FSM and the three output FIFOs of a 1x3 router.
//   - latches the destination address when a header is seen
//   - steers the FSM write strobe to the addressed FIFO
//   - reports the addressed FIFO's full flag and per-FIFO valid data
//   - runs one read-timeout watchdog per FIFO
// Ports:
//   clock, resetn                  clock and synchronous active-low reset
//   data_in[1:0], detect_add       header address and capture strobe
//   full_0..2, empty_0..2          FIFO status flags
//   write_enb_reg                  FSM write request
//   read_enb_0..2                  downstream read strobes
//   write_enb[2:0]                 one-hot FIFO write enables
//   fifo_full                      full flag of addressed FIFO
//   vld_out_0..2                   FIFO x holds data
//   soft_reset_0..2                one-cycle soft-reset pulses
// -----------------------------------------------------------------------------
module router_sync
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              detect_add,
  input  logic              full_0,
  input  logic              full_1,
  input  logic              full_2,
  input  logic              empty_0,
  input  logic              empty_1,
  input  logic              empty_2,
  input  logic              write_enb_reg,
  input  logic              read_enb_0,
  input  logic              read_enb_1,
  input  logic              read_enb_2,
  output logic [2:0]        write_enb,
  output logic              fifo_full,
  output logic              vld_out_0,
  output logic              vld_out_1,
  output logic              vld_out_2,
  output logic              soft_reset_0,
  output logic              soft_reset_1,
  output logic              soft_reset_2
);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;

  // Address capture: hold the header address for the whole packet.
  always_comb begin
    addr_d = addr_q;
    if (detect_add) begin
      addr_d = data_in;
    end else begin
      addr_d = addr_q;
    end
  end

  // Address register with synchronous reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      addr_q <= ADDR_F0;
    end else begin
      addr_q <= addr_d;
    end
  end

  // Write steering uses the registered address, so a header arriving with a
  // write request still targets the previous FIFO in that cycle.
  always_comb begin
    write_enb = 3'b000;
    if (write_enb_reg) begin
      write_enb = addr_to_onehot(addr_q);
    end else begin
      write_enb = 3'b000;
    end
  end

  // Full-flag mux for the addressed FIFO; invalid address reports not full.
  always_comb begin
    fifo_full = 1'b0;
    case (addr_q)
      ADDR_F0: fifo_full = full_0;
      ADDR_F1: fifo_full = full_1;
      ADDR_F2: fifo_full = full_2;
      default: fifo_full = 1'b0;
    endcase
  end

  assign vld_out_0 = ~empty_0;
  assign vld_out_1 = ~empty_1;
  assign vld_out_2 = ~empty_2;

  router_sync_timeout #(.TIMEOUT_P(TIMEOUT)) u_wd0 (
    .clock      (clock),
    .resetn     (resetn),
    .vld        (vld_out_0),
    .read_enb   (read_enb_0),
    .soft_reset (soft_reset_0)
  );

  router_sync_timeout #(.TIMEOUT_P(TIMEOUT)) u_wd1 (
    .clock      (clock),
    .resetn     (resetn),
    .vld        (vld_out_1),
    .read_enb   (read_enb_1),
    .soft_reset (soft_reset_1)
  );

  router_sync_timeout #(.TIMEOUT_P(TIMEOUT)) u_wd2 (
    .clock      (clock),
    .resetn     (resetn),
    .vld        (vld_out_2),
    .read_enb   (read_enb_2),
    .soft_reset (soft_reset_2)
  );

endmodule

// File: tb/tb_router_sync.sv
// -----------------------------------------------------------------------------
// tb_router_sync
// Directed bench for router_sync. Expected values are queued when stimulus is
// driven and popped when the matching DUT output is sampled (negedge or #1
// after a combinational input change).
// -----------------------------------------------------------------------------
module tb_router_sync;

  logic       clock = 1'b0;
  logic       resetn;
  logic [1:0] data_in;
  logic       detect_add;
  logic       full_0, full_1, full_2;
  logic       empty_0, empty_1, empty_2;
  logic       write_enb_reg;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];

  router_sync dut (
    .clock         (clock),
    .resetn        (resetn),
    .data_in       (data_in),
    .detect_add    (detect_add),
    .full_0        (full_0),
    .full_1        (full_1),
    .full_2        (full_2),
    .empty_0       (empty_0),
    .empty_1       (empty_1),
    .empty_2       (empty_2),
    .write_enb_reg (write_enb_reg),
    .read_enb_0    (read_enb_0),
    .read_enb_1    (read_enb_1),
    .read_enb_2    (read_enb_2),
    .write_enb     (write_enb),
    .fifo_full     (fifo_full),
    .vld_out_0     (vld_out_0),
    .vld_out_1     (vld_out_1),
    .vld_out_2     (vld_out_2),
    .soft_reset_0  (soft_reset_0),
    .soft_reset_1  (soft_reset_1),
    .soft_reset_2  (soft_reset_2)
  );

  always #5 clock = ~clock;

  task automatic push_exp(input string tag, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic compare(input logic [7:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL sb_underflow observed=%0h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  // Advance one rising edge and land on the following falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic logic [7:0] sr_vec();
    return {5'b00000, soft_reset_2, soft_reset_1, soft_reset_0};
  endfunction

  function automatic logic [7:0] vld_vec();
    return {5'b00000, vld_out_2, vld_out_1, vld_out_0};
  endfunction

  initial begin
    resetn = 1'b0; data_in = 2'b00; detect_add = 1'b0;
    full_0 = 1'b0; full_1 = 1'b0; full_2 = 1'b0;
    empty_0 = 1'b1; empty_1 = 1'b1; empty_2 = 1'b1;
    write_enb_reg = 1'b0;
    read_enb_0 = 1'b0; read_enb_1 = 1'b0; read_enb_2 = 1'b0;

    // Reset state
    @(negedge clock);
    tick(); tick();
    push_exp("rst_we", 8'h00);   compare({5'b00000, write_enb});
    push_exp("rst_full", 8'h00); compare({7'b0000000, fifo_full});
    push_exp("rst_vld", 8'h00);  compare(vld_vec());
    push_exp("rst_sr", 8'h00);   compare(sr_vec());
    write_enb_reg = 1'b1; #1;
    push_exp("rst_we_addr0", 8'h01); compare({5'b00000, write_enb});
    write_enb_reg = 1'b0;
    resetn = 1'b1;

    // Test 1: address 00
    data_in = 2'b00; detect_add = 1'b1; write_enb_reg = 1'b1;
    push_exp("t1_we", 8'h01);
    tick(); detect_add = 1'b0; #1;
    compare({5'b00000, write_enb});
    full_0 = 1'b1; #1;
    push_exp("t1_full0", 8'h01); compare({7'b0000000, fifo_full});

    // Test 2: address 10, old address used in the capture cycle
    full_0 = 1'b0; data_in = 2'b10; detect_add = 1'b1; #1;
    push_exp("t2_we_old", 8'h01); compare({5'b00000, write_enb});
    tick(); detect_add = 1'b0; #1;
    push_exp("t2_we", 8'h04); compare({5'b00000, write_enb});
    full_0 = 1'b1; #1;
    push_exp("t2_full0_ign", 8'h00); compare({7'b0000000, fifo_full});
    full_2 = 1'b1; #1;
    push_exp("t2_full2", 8'h01); compare({7'b0000000, fifo_full});
    full_1 = 1'b1; #1;
    push_exp("t2_full1_ign", 8'h01); compare({7'b0000000, fifo_full});

    // Test 3: invalid address 11, then 01 with and without write request
    data_in = 2'b11; detect_add = 1'b1;
    tick(); detect_add = 1'b0; #1;
    push_exp("t3_we_inv", 8'h00);   compare({5'b00000, write_enb});
    push_exp("t3_full_inv", 8'h00); compare({7'b0000000, fifo_full});
    write_enb_reg = 1'b0; data_in = 2'b01; detect_add = 1'b1;
    tick(); detect_add = 1'b0; #1;
    push_exp("t3_we_off", 8'h00);  compare({5'b00000, write_enb});
    push_exp("t3_full1", 8'h01);   compare({7'b0000000, fifo_full});
    full_1 = 1'b0; #1;
    push_exp("t3_full1_lo", 8'h00); compare({7'b0000000, fifo_full});
    write_enb_reg = 1'b1; #1;
    push_exp("t3_we_f1", 8'h02);   compare({5'b00000, write_enb});
    write_enb_reg = 1'b0; full_0 = 1'b0; full_2 = 1'b0;

    // Test 4: FIFO 1 unread, pulses after edge 30 and 60
    empty_1 = 1'b0; #1;
    push_exp("t4_vld", 8'h02); compare(vld_vec());
    for (int n = 1; n <= 61; n++) begin
      push_exp($sformatf("t4_sr_n%0d", n), {5'b00000, 1'b0, (n == 30 || n == 60), 1'b0});
      tick();
      compare(sr_vec());
    end
    empty_1 = 1'b1; #1;
    push_exp("t4_vld_off", 8'h00); compare(vld_vec());
    tick();

    // Test 5a: read at edge 20 restarts the count
    empty_1 = 1'b0;
    for (int n = 1; n <= 55; n++) begin
      read_enb_1 = (n == 20);
      push_exp($sformatf("t5a_sr_n%0d", n), {5'b00000, 1'b0, (n == 50), 1'b0});
      tick();
      compare(sr_vec());
    end
    read_enb_1 = 1'b0; empty_1 = 1'b1;
    tick();

    // Test 5b: reset at edge 25 aborts the count; restart after release
    empty_1 = 1'b0;
    for (int n = 1; n <= 56; n++) begin
      resetn = (n != 25);
      push_exp($sformatf("t5b_sr_n%0d", n), {5'b00000, 1'b0, (n == 55), 1'b0});
      tick();
      compare(sr_vec());
    end
    resetn = 1'b1; empty_1 = 1'b1;
    tick();

    // Test 6: FIFO 0 from edge 1, FIFO 2 from edge 6
    empty_0 = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      empty_2 = (n < 6);
      push_exp($sformatf("t6_sr_n%0d", n), {5'b00000, (n == 35), 1'b0, (n == 30)});
      tick();
      compare(sr_vec());
    end
    push_exp("t6_vld", 8'h05); compare(vld_vec());

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
